// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, port-owner encoding,
// timeout timer width and a counter-width helper.
package sdram_arb_pkg;

  localparam int TIMER_W = 6;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_DMA_ADDR   = 3'd2,
    ST_DMA_STROBE = 3'd3,
    ST_DMA_REL    = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  // Bits needed for a counter that saturates at max_val (at least one bit).
  function automatic int sat_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between CPU glue, DMA requester, SDRAM controller and the arbiter.
// slave = arbiter side, master = surrounding system side.
interface sdram_port_arbiter_if;
  logic        CPU_AS;
  logic        CPU_UDS;
  logic        CPU_LDS;
  logic        CPU_RW;
  logic [23:1] CPU_A;
  logic        CPU_DTACK;
  logic        DMA_REQ;
  logic        DMA_RW;
  logic [23:1] DMA_A;
  logic [1:0]  DMA_BE;
  logic        DMA_GNT;
  logic        DMA_DONE;
  logic        DMA_ERR;
  logic        MEM_AS;
  logic        MEM_UDS;
  logic        MEM_LDS;
  logic        MEM_RW;
  logic [23:1] MEM_A;
  logic        MEM_VALID;
  logic        MEM_READY;

  modport slave (
    input  CPU_AS, CPU_UDS, CPU_LDS, CPU_RW, CPU_A,
    input  DMA_REQ, DMA_RW, DMA_A, DMA_BE,
    input  MEM_VALID, MEM_READY,
    output CPU_DTACK, DMA_GNT, DMA_DONE, DMA_ERR,
    output MEM_AS, MEM_UDS, MEM_LDS, MEM_RW, MEM_A
  );

  modport master (
    output CPU_AS, CPU_UDS, CPU_LDS, CPU_RW, CPU_A,
    output DMA_REQ, DMA_RW, DMA_A, DMA_BE,
    output MEM_VALID, MEM_READY,
    input  CPU_DTACK, DMA_GNT, DMA_DONE, DMA_ERR,
    input  MEM_AS, MEM_UDS, MEM_LDS, MEM_RW, MEM_A
  );
endinterface

// File: rtl/sdram_arb_timer.sv
// Loadable up-counter with a terminal-count compare, used to time out DMA strobes.
module sdram_arb_timer
  import sdram_arb_pkg::*;
#(
  parameter int TERM = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               term
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: a load takes priority over counting.
  always_comb begin
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + TIMER_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign term = (count_q == TIMER_W'(TERM));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Parks the SDRAM controller port on the 68000 and slots DMA cycles into CPU bus gaps.
// Optional feature macro: ARB_FAIRNESS_EN (starvation-based forced DMA grant).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int IDLE_GAP     = 2,
`ifdef ARB_FAIRNESS_EN
  parameter int STARVE_LIMIT = 4,
`endif
  parameter int TIMEOUT      = 63
) (
  input  logic                 CLK,
  input  logic                 RST,
  sdram_port_arbiter_if.slave  bus
);

  localparam int GAP_W = sat_width(IDLE_GAP);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               rel_q, rel_d;
  logic               gnt_q, gnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               mem_as_q, mem_as_d;
  logic               mem_uds_q, mem_uds_d;
  logic               mem_lds_q, mem_lds_d;
  logic               mem_rw_q, mem_rw_d;
  logic [23:1]        mem_a_q, mem_a_d;
  logic [1:0]         be_q, be_d;
  logic               tmr_load_s;
  logic               tmr_en_s;
  logic               tmr_term_s;
  logic               gap_ok_s;
  logic               starve_hit_s;
  logic               grant_s;

  sdram_arb_timer #(
    .TERM (TIMEOUT)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load_s),
    .load_val (TIMER_W'(1)),
    .en       (tmr_en_s),
    .term     (tmr_term_s)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int STARVE_W = sat_width(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [STARVE_W-1:0] starve_inc_s;
  logic                as_prev_q, as_prev_d;

  // Count completed CPU cycles (AS rising samples) that pass while DMA waits.
  always_comb begin
    as_prev_d = bus.CPU_AS;
    if ((state_q == ST_IDLE) && bus.CPU_AS && !as_prev_q && bus.DMA_REQ &&
        (int'(starve_q) < STARVE_LIMIT)) begin
      starve_inc_s = starve_q + STARVE_W'(1);
    end else begin
      starve_inc_s = starve_q;
    end
    starve_hit_s = (int'(starve_inc_s) >= STARVE_LIMIT);
  end

  // Starvation count clears when DMA finally wins the port.
  always_comb begin
    if (grant_s) begin
      starve_d = {STARVE_W{1'b0}};
    end else if (state_q == ST_IDLE) begin
      starve_d = starve_inc_s;
    end else begin
      starve_d = starve_q;
    end
  end

  // Fairness registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q  <= {STARVE_W{1'b0}};
      as_prev_q <= 1'b1;
    end else begin
      starve_q  <= starve_d;
      as_prev_q <= as_prev_d;
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  // Grant only on a sample where the CPU is off the bus, so no cycle gets spliced.
  assign gap_ok_s = (int'(gap_q) >= (IDLE_GAP - 1));
  assign grant_s  = (state_q == ST_IDLE) && bus.DMA_REQ && bus.CPU_AS &&
                    (gap_ok_s || starve_hit_s);

  // Arbitration FSM next-state and DMA-side bus register values.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gap_d      = gap_q;
    rel_d      = rel_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_as_d   = mem_as_q;
    mem_uds_d  = mem_uds_q;
    mem_lds_d  = mem_lds_q;
    mem_rw_d   = mem_rw_q;
    mem_a_d    = mem_a_q;
    be_d       = be_q;
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (!bus.MEM_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (grant_s) begin
          state_d   = ST_DMA_ADDR;
          owner_d   = OWNER_DMA;
          gnt_d     = 1'b1;
          gap_d     = {GAP_W{1'b0}};
          mem_as_d  = 1'b0;
          mem_uds_d = 1'b1;
          mem_lds_d = 1'b1;
          mem_rw_d  = bus.DMA_RW;
          mem_a_d   = bus.DMA_A;
          be_d      = bus.DMA_BE;
        end else if (bus.CPU_AS) begin
          if (int'(gap_q) < IDLE_GAP) begin
            gap_d = gap_q + GAP_W'(1);
          end else begin
            gap_d = gap_q;
          end
        end else begin
          gap_d = {GAP_W{1'b0}};
        end
      end
      ST_DMA_ADDR: begin
        state_d    = ST_DMA_STROBE;
        mem_uds_d  = ~be_q[1];
        mem_lds_d  = ~be_q[0];
        tmr_load_s = 1'b1;
      end
      ST_DMA_STROBE: begin
        tmr_en_s = 1'b1;
        if (!bus.MEM_VALID || tmr_term_s) begin
          done_d    = !bus.MEM_VALID;
          err_d     = bus.MEM_VALID;
          state_d   = ST_DMA_REL;
          gnt_d     = 1'b0;
          rel_d     = 1'b0;
          mem_as_d  = 1'b1;
          mem_uds_d = 1'b1;
          mem_lds_d = 1'b1;
        end else begin
          state_d = ST_DMA_STROBE;
        end
      end
      ST_DMA_REL: begin
        // A CPU cycle stalled during DMA restarts cleanly: AS was negated here.
        if (!rel_q) begin
          rel_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          owner_d = OWNER_CPU;
          rel_d   = 1'b0;
          gap_d   = {GAP_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_INIT;
        owner_d = OWNER_CPU;
        gnt_d   = 1'b0;
      end
    endcase
  end

  // FSM and DMA bus registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_INIT;
      owner_q   <= OWNER_CPU;
      gap_q     <= {GAP_W{1'b0}};
      rel_q     <= 1'b0;
      gnt_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_as_q  <= 1'b1;
      mem_uds_q <= 1'b1;
      mem_lds_q <= 1'b1;
      mem_rw_q  <= 1'b1;
      mem_a_q   <= 23'd0;
      be_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gap_q     <= gap_d;
      rel_q     <= rel_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mem_as_q  <= mem_as_d;
      mem_uds_q <= mem_uds_d;
      mem_lds_q <= mem_lds_d;
      mem_rw_q  <= mem_rw_d;
      mem_a_q   <= mem_a_d;
      be_q      <= be_d;
    end
  end

  // Controller-side mux: zero-latency CPU pass-through, registered DMA cycle.
  always_comb begin
    if (owner_q == OWNER_CPU) begin
      bus.MEM_AS    = bus.CPU_AS;
      bus.MEM_UDS   = bus.CPU_UDS;
      bus.MEM_LDS   = bus.CPU_LDS;
      bus.MEM_RW    = bus.CPU_RW;
      bus.MEM_A     = bus.CPU_A;
      bus.CPU_DTACK = bus.MEM_VALID;
    end else begin
      bus.MEM_AS    = mem_as_q;
      bus.MEM_UDS   = mem_uds_q;
      bus.MEM_LDS   = mem_lds_q;
      bus.MEM_RW    = mem_rw_q;
      bus.MEM_A     = mem_a_q;
      bus.CPU_DTACK = 1'b1;
    end
  end

  assign bus.DMA_GNT  = gnt_q;
  assign bus.DMA_DONE = done_q;
  assign bus.DMA_ERR  = err_q;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single 68k-style port of the SDRAM controller between the 68000 CPU and one secondary DMA/blitter requester. The block parks ownership on the CPU, so an idle CPU cycle passes straight through with zero added latency. It grants the DMA master only in CPU bus gaps and sequences a complete AS/DS cycle on its behalf. It sits between the CPU bus glue and the SDRAM controller, routes the controller's active-low VALID back to whichever master owns the port, and holds off DMA until controller initialisation completes.

## Interface
Parameters:
- IDLE_GAP, 2: consecutive CPU_AS-high samples required before a DMA grant (strict-priority rule).
- STARVE_LIMIT, 4: completed CPU cycles with DMA_REQ pending before fairness forces a grant (ARB_FAIRNESS_EN only).
- TIMEOUT, 63: maximum cycles from DMA strobe to MEM_VALID low before the cycle is aborted; 6-bit counter.

Ports:
- CLK  in  1  system clock (66 MHz); every register on posedge.
- RST  in  1  synchronous, active-high reset.
- CPU_AS, CPU_UDS, CPU_LDS, CPU_RW  in  1 each  68k strobes, active low except RW (1 = read).
- CPU_A  in  [23:1]  CPU address.
- CPU_DTACK  out  1  active low; equals MEM_VALID when owner is CPU, else 1.
- DMA_REQ  in  1  level request; held until DMA_DONE or DMA_ERR.
- DMA_RW  in  1  1 = read.
- DMA_A  in  [23:1]  DMA address.
- DMA_BE  in  [1:0]  active-high byte enables, [1] = upper.
- DMA_GNT  out  1  high while DMA owns the port.
- DMA_DONE  out  1  one-cycle pulse at completion.
- DMA_ERR  out  1  one-cycle pulse on timeout.
- MEM_AS, MEM_UDS, MEM_LDS, MEM_RW  out  1 each  to the controller.
- MEM_A  out  [23:1]  to the controller.
- MEM_VALID  in  1  controller VALID, active low.
- MEM_READY  in  1  controller init in progress while high.

## Operation
- Registered owner bit: CPU or DMA. When the owner is CPU, MEM_* is a combinational pass-through of CPU_*. When the owner is DMA, MEM_* comes from registers.
- States:
  - INIT: owner CPU. Exits to IDLE on the first cycle MEM_READY samples low.
  - IDLE: owner CPU. Gap counter increments while CPU_AS is high (saturating) and clears when CPU_AS is low. Goes to DMA_ADDR when DMA_REQ && CPU_AS && gap ≥ IDLE_GAP−1.
  - DMA_ADDR: owner DMA, DMA_GNT=1. MEM_AS=0, MEM_RW=DMA_RW, MEM_A=DMA_A latched, MEM_UDS/LDS=1. Next state is DMA_STROBE.
  - DMA_STROBE: MEM_UDS=~DMA_BE[1], MEM_LDS=~DMA_BE[0]. Timer runs. On MEM_VALID=0, pulse DMA_DONE and go to DMA_REL. On timer==TIMEOUT, pulse DMA_ERR and go to DMA_REL.
  - DMA_REL: all MEM strobes 1 for 2 cycles so the controller sees AS negate. Then owner returns to CPU and the state goes to IDLE with the gap counter cleared. DMA_GNT is 0 from the first DMA_REL cycle.
- A CPU_AS assertion while the owner is DMA is simply stalled: CPU_DTACK stays 1 until the CPU owns the port again.
- DMA_BE=00 is still run as a full cycle with both DS high. The controller never asserts VALID, so the cycle ends in timeout and DMA_ERR fires; the requester must not issue it.
- Simultaneous DMA_REQ and CPU_AS low in the same sample: CPU wins and no grant is issued.
- DMA_REQ dropping mid-cycle is ignored; the cycle completes.

## Timing
- Reset values: state INIT, owner CPU, DMA_GNT=0, DMA_DONE=0, DMA_ERR=0, counters 0. MEM_* follow CPU_*. CPU_DTACK follows MEM_VALID.
- Reset mid-DMA: owner CPU on the next edge and MEM_* revert to CPU pass-through. No DONE or ERR pulse.
- CPU path latency: 0 cycles (combinational).
- DMA latency: the grant decision edge is followed by DMA_ADDR (1 cycle), then DMA_STROBE (≥1 cycle until MEM_VALID), then DMA_REL (2 cycles).
- DMA_DONE and DMA_ERR are registered and coincide with the first DMA_REL cycle. They are mutually exclusive.
- Ownership changes only on clock edges on which CPU_AS sampled high, so the controller never sees a spliced cycle.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A starvation counter increments on each CPU_AS rising sample while DMA_REQ=1.
  - Once the counter reaches ≥ STARVE_LIMIT, the grant occurs on the first CPU_AS-high sample, ignoring IDLE_GAP.
  - The counter clears on grant.
- Undefined: strict CPU priority (IDLE_GAP rule only). The counter is not built.

## Structure
- Package sdram_arb_pkg holds the state enum (INIT, IDLE, DMA_ADDR, DMA_STROBE, DMA_REL), the owner encoding and the timer width constant.
- One sub-module, sdram_arb_timer: a loadable 6-bit up-counter with terminal-compare output, used for the TIMEOUT check.

## Test plan
- MEM_READY high for 100 cycles with DMA_REQ=1 -> no DMA_GNT until 2 cycles after MEM_READY falls.
- CPU read at 0x001000 with DMA idle -> MEM_AS tracks CPU_AS in the same cycle and CPU_DTACK mirrors MEM_VALID.
- DMA write at 0x0A0000 with BE=01 and CPU idle -> DMA_ADDR then DMA_STROBE with MEM_UDS=1, MEM_LDS=0. DMA_DONE pulses the cycle after MEM_VALID=0, followed by 2 release cycles.
- MEM_VALID held high -> DMA_ERR pulses exactly 63 cycles after DMA_STROBE entry, and the owner returns to CPU.
- Back-to-back CPU cycles with a 1-cycle AS gap and DMA_REQ=1 -> no grant without ARB_FAIRNESS_EN; with it, grant after the 4th completed CPU cycle.
- RST asserted during DMA_STROBE -> next cycle DMA_GNT=0, MEM_AS=CPU_AS, no DONE or ERR pulse.
